// File: rtl/hex_operand_entry.sv
// rtl/hex_operand_entry.sv - hex operand keypad entry with ALU result/flag capture
//
// Ports:
//   CLOCK_50      in   system clock
//   rst           in   synchronous reset, active-low
//   digit_in      in   switch value for the digit under the cursor
//   view_sel      in   operand index, or any value >= NUM_OPERANDS for the result view
//   enter_n       in   raw key (active-low): lock digit, advance cursor
//   backspace_n   in   raw key (active-low): move cursor back
//   clear_n       in   raw key (active-low): zero viewed operand, cursor to 0
//   run_n         in   raw key (active-low): capture ALU result and flags
//   alu_result    in   ALU result
//   alu_flags     in   {Z,V,C,N}
//   operands      out  operand i at [i*OP_W +: OP_W]
//   hex_value     out  digit d at [4d +: 4]
//   hex_off       out  1 = blank digit d
//   hex_tag       out  4'hA+i in operand view i, 4'h0 in result view
//   flags         out  latched flags in result view, 0 otherwise
//   result_valid  out  a run capture has occurred since reset
//   cursor        out  cursor of the viewed operand, 0 in result view
module hex_operand_entry #(
    parameter int NUM_OPERANDS = 2,
    parameter int DIGITS       = 4,
    parameter int SEL_W        = 3,
    parameter int OP_W         = 4 * DIGITS,
    parameter int CW           = $clog2(DIGITS + 1)
) (
    input  logic                         CLOCK_50,
    input  logic                         rst,
    input  logic [3:0]                   digit_in,
    input  logic [SEL_W-1:0]             view_sel,
    input  logic                         enter_n,
    input  logic                         backspace_n,
    input  logic                         clear_n,
    input  logic                         run_n,
    input  logic [OP_W-1:0]              alu_result,
    input  logic [3:0]                   alu_flags,
    output logic [NUM_OPERANDS*OP_W-1:0] operands,
    output logic [4*DIGITS-1:0]          hex_value,
    output logic [DIGITS-1:0]            hex_off,
    output logic [3:0]                   hex_tag,
    output logic [3:0]                   flags,
    output logic                         result_valid,
    output logic [CW-1:0]                cursor
);

    logic [OP_W-1:0] r_ops [NUM_OPERANDS];
    logic [CW-1:0]   r_cur [NUM_OPERANDS];
    logic [OP_W-1:0] r_result;
    logic [3:0]      r_flags;
    logic            r_valid;

    // Key order in the synchroniser vectors: {run, clear, backspace, enter}
    logic [3:0] r_s1, r_s2, r_prev;
    logic [3:0] w_keys, w_press;
    logic       w_en_p, w_bs_p, w_clr_p, w_run_p;
    logic       w_view_op;

    assign w_keys    = {run_n, clear_n, backspace_n, enter_n};
    // One-cycle pulse on each synchronised falling edge; a held key never repeats
    assign w_press   = r_prev & ~r_s2;
    assign w_en_p    = w_press[0];
    assign w_bs_p    = w_press[1];
    assign w_clr_p   = w_press[2];
    assign w_run_p   = w_press[3];
    assign w_view_op = int'(view_sel) < NUM_OPERANDS;

    always_ff @(posedge CLOCK_50) begin
        if (!rst) begin
            r_s1     <= 4'hF;
            r_s2     <= 4'hF;
            r_prev   <= 4'hF;
            r_result <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                r_ops[i] <= '0;
                r_cur[i] <= '0;
            end
        end else begin
            r_s1   <= w_keys;
            r_s2   <= r_s1;
            r_prev <= r_s2;

            if (w_run_p) begin
                r_result <= alu_result;
                r_flags  <= alu_flags;
                r_valid  <= 1'b1;
            end

            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (w_view_op && int'(view_sel) == i) begin
                    if (w_clr_p) begin
                        r_ops[i] <= '0;
                        r_cur[i] <= '0;
                    end else begin
                        // Open digit follows the switches every cycle until entered
                        if (r_cur[i] < CW'(DIGITS)) begin
                            for (int d = 0; d < DIGITS; d++) begin
                                if (d == DIGITS - 1 - int'(r_cur[i]))
                                    r_ops[i][4*d +: 4] <= digit_in;
                            end
                        end
                        if (w_bs_p) begin
                            if (r_cur[i] != '0)
                                r_cur[i] <= r_cur[i] - CW'(1);
                        end else if (w_en_p) begin
                            if (r_cur[i] != CW'(DIGITS))
                                r_cur[i] <= r_cur[i] + CW'(1);
                        end
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_ops
            assign operands[g*OP_W +: OP_W] = r_ops[g];
        end
    endgenerate

    logic [OP_W-1:0] w_sel_op;
    logic [CW-1:0]   w_sel_cur;
    logic [3:0]      w_sel_tag;

    always_comb begin
        w_sel_op  = '0;
        w_sel_cur = '0;
        w_sel_tag = 4'h0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (int'(view_sel) == i) begin
                w_sel_op  = r_ops[i];
                w_sel_cur = r_cur[i];
                w_sel_tag = 4'hA + 4'(i);
            end
        end
    end

    always_comb begin
        hex_off = '0;
        if (w_view_op && w_sel_cur < CW'(DIGITS)) begin
            // Blank the not-yet-reached digits to the right of the cursor
            for (int d = 0; d < DIGITS; d++) begin
                if (d < DIGITS - 1 - int'(w_sel_cur))
                    hex_off[d] = 1'b1;
            end
        end
    end

    assign hex_value    = w_view_op ? w_sel_op  : r_result;
    assign hex_tag      = w_view_op ? w_sel_tag : 4'h0;
    assign flags        = w_view_op ? 4'h0      : r_flags;
    assign cursor       = w_view_op ? w_sel_cur : '0;
    assign result_valid = r_valid;

endmodule

// File: tb/tb_hex_operand_entry.sv
// tb/tb_hex_operand_entry.sv - scoreboard bench for hex_operand_entry
module tb_hex_operand_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit_in;
    logic [2:0]  view_sel;
    logic        enter_n, backspace_n, clear_n, run_n;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic [31:0] operands;
    logic [15:0] hex_value;
    logic [3:0]  hex_off;
    logic [3:0]  hex_tag;
    logic [3:0]  flags;
    logic        result_valid;
    logic [2:0]  cursor;

    hex_operand_entry dut (
        .CLOCK_50     (clk),
        .rst          (rst),
        .digit_in     (digit_in),
        .view_sel     (view_sel),
        .enter_n      (enter_n),
        .backspace_n  (backspace_n),
        .clear_n      (clear_n),
        .run_n        (run_n),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .operands     (operands),
        .hex_value    (hex_value),
        .hex_off      (hex_off),
        .hex_tag      (hex_tag),
        .flags        (flags),
        .result_valid (result_valid),
        .cursor       (cursor)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // m = {run, clear, backspace, enter}; low for one edge, then settle past the action edge
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        enter_n     = ~m[0];
        backspace_n = ~m[1];
        clear_n     = ~m[2];
        run_n       = ~m[3];
        @(negedge clk);
        {run_n, clear_n, backspace_n, enter_n} = 4'hF;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; digit_in = 4'h0; view_sel = 3'd0;
        {run_n, clear_n, backspace_n, enter_n} = 4'hF;
        alu_result = 16'h0; alu_flags = 4'h0;

        // T1 reset
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push("t1_operands", 32'h0);      observe(32'(operands));
        push("t1_hex_off", 32'h7);       observe(32'(hex_off));
        push("t1_hex_tag", 32'hA);       observe(32'(hex_tag));
        push("t1_result_valid", 32'h0);  observe(32'(result_valid));
        push("t1_flags", 32'h0);         observe(32'(flags));
        push("t1_cursor", 32'h0);        observe(32'(cursor));

        // T2 entry on operand 0
        digit_in = 4'h3; press(4'b0001);
        push("t2_cursor1", 32'd1);       observe(32'(cursor));
        push("t2_hex_off1", 32'h3);      observe(32'(hex_off));
        digit_in = 4'h7; press(4'b0001);
        digit_in = 4'h0; press(4'b0001);
        digit_in = 4'hF; press(4'b0001);
        push("t2_operand0", 32'h370F);   observe(32'(operands[15:0]));
        push("t2_cursor4", 32'd4);       observe(32'(cursor));
        push("t2_hex_off4", 32'h0);      observe(32'(hex_off));
        digit_in = 4'h5; press(4'b0001);
        push("t2_frozen_op", 32'h370F);  observe(32'(operands[15:0]));
        push("t2_frozen_cur", 32'd4);    observe(32'(cursor));

        // T3 backspace
        digit_in = 4'h9;
        press(4'b0010); press(4'b0010);
        push("t3_operand0", 32'h3799);   observe(32'(operands[15:0]));
        push("t3_cursor2", 32'd2);       observe(32'(cursor));
        push("t3_hex_off2", 32'h1);      observe(32'(hex_off));
        for (int k = 0; k < 5; k++) press(4'b0010);
        push("t3_cursor0", 32'd0);       observe(32'(cursor));
        push("t3_operand_all9", 32'h9999); observe(32'(operands[15:0]));

        // T4 run capture
        alu_result = 16'hBEEF; alu_flags = 4'b0010;
        press(4'b1000);
        push("t4_flags_opview", 32'h0);  observe(32'(flags));
        view_sel = 3'd2;
        @(negedge clk);
        push("t4_hex_value", 32'hBEEF);  observe(32'(hex_value));
        push("t4_flags", 32'h2);         observe(32'(flags));
        push("t4_result_valid", 32'h1);  observe(32'(result_valid));
        push("t4_hex_tag", 32'h0);       observe(32'(hex_tag));
        push("t4_hex_off", 32'h0);       observe(32'(hex_off));
        alu_result = 16'h1234; alu_flags = 4'hF;
        repeat (3) @(negedge clk);
        push("t4_hold", 32'hBEEF);       observe(32'(hex_value));
        press(4'b0011);
        push("t4_resview_keys", 32'h9999); observe(32'(operands[15:0]));

        // T5 clear+enter together, then held enter
        view_sel = 3'd0; digit_in = 4'h0;
        press(4'b0101);
        push("t5_clear_op", 32'h0);      observe(32'(operands[15:0]));
        push("t5_clear_cur", 32'd0);     observe(32'(cursor));
        @(negedge clk); enter_n = 1'b0;
        repeat (20) @(negedge clk);
        enter_n = 1'b1;
        repeat (3) @(negedge clk);
        push("t5_hold_cur", 32'd1);      observe(32'(cursor));

        // T6 isolation between operands, then reset mid-entry
        view_sel = 3'd1;
        digit_in = 4'hC; press(4'b0001);
        digit_in = 4'hD; press(4'b0001);
        push("t6_op1", 32'hCDD0);        observe(32'(operands[31:16]));
        push("t6_tag1", 32'hB);          observe(32'(hex_tag));
        view_sel = 3'd0; digit_in = 4'h5;
        repeat (3) @(negedge clk);
        push("t6_op0", 32'h0500);        observe(32'(operands[15:0]));
        push("t6_op1_kept", 32'hCDD0);   observe(32'(operands[31:16]));
        push("t6_cur0", 32'd1);          observe(32'(cursor));
        digit_in = 4'hD; view_sel = 3'd1;
        @(negedge clk);
        push("t6_cur1_kept", 32'd2);     observe(32'(cursor));
        push("t6_op1_back", 32'hCDD0);   observe(32'(operands[31:16]));

        digit_in = 4'h0;
        enter_n = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        enter_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        push("t6_rst_ops", 32'h0);       observe(operands);
        push("t6_rst_cur", 32'd0);       observe(32'(cursor));
        push("t6_rst_valid", 32'h0);     observe(32'(result_valid));
        view_sel = 3'd7;
        @(negedge clk);
        push("t6_rst_result", 32'h0);    observe(32'(hex_value));
        push("t6_rst_flags", 32'h0);     observe(32'(flags));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
